// File: rtl/div_share_arb.sv
// Round-robin sequencer sharing one iterative unsigned divider between N_REQ requesters.
// Divide-by-zero requests are answered locally without starting the divider.
module div_share_arb #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   dividend,
  input  logic [N_REQ*DATA_W-1:0]   divisor,
  output logic [N_REQ-1:0]          grant,
  output logic [N_REQ-1:0]          done,
  output logic [DATA_W-1:0]         quotient,
  output logic [DATA_W-1:0]         remainder,
  output logic                      div_zero,
  output logic                      div_start,
  output logic [DATA_W-1:0]         div_dividend,
  output logic [DATA_W-1:0]         div_divisor,
  input  logic                      div_done,
  input  logic [DATA_W-1:0]         div_quotient,
  input  logic [DATA_W-1:0]         div_remainder
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_ZERO,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               zero_q, zero_d;

  logic [N_REQ-1:0]   grant_d, done_d;
  logic [DATA_W-1:0]  quo_d, rem_d, dd_d, dv_d;
  logic               start_d, dz_d;

  logic [IDX_W-1:0]   win_c;
  logic               win_vld_c;
  logic [DATA_W-1:0]  win_a_c, win_b_c;

  // Round-robin search from ptr; walking offsets downward lets the lowest offset win.
  always_comb begin
    int unsigned pos;
    pos       = 0;
    win_c     = '0;
    win_vld_c = 1'b0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      pos = 32'(ptr_q) + (i - 1);
      if (pos >= N_REQ) begin
        pos = pos - N_REQ;
      end
      if (req[IDX_W'(pos)]) begin
        win_c     = IDX_W'(pos);
        win_vld_c = 1'b1;
      end
    end
  end

  // Operand mux for the current winner.
  always_comb begin
    win_a_c = '0;
    win_b_c = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (win_c == IDX_W'(k)) begin
        win_a_c = dividend[k*DATA_W +: DATA_W];
        win_b_c = divisor[k*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    zero_d   = zero_q;
    grant_d  = '0;
    done_d   = '0;
    start_d  = 1'b0;
    dz_d     = 1'b0;
    quo_d    = quotient;
    rem_d    = remainder;
    dd_d     = div_dividend;
    dv_d     = div_divisor;

    unique case (state_q)
      S_IDLE: begin
        if (win_vld_c) begin
          owner_d = win_c;
          grant_d = N_REQ'(1) << win_c;
          dd_d    = win_a_c;
          dv_d    = win_b_c;
          zero_d  = (win_b_c == '0);
          start_d = (win_b_c != '0);
          state_d = S_START;
        end
      end
      // Zero-divisor requests also spend this cycle here (without a start pulse),
      // so their done lands two cycles after grant.
      S_START: begin
        state_d = zero_q ? S_ZERO : S_BUSY;
      end
      S_BUSY: begin
        if (div_done) begin
          quo_d   = div_quotient;
          rem_d   = div_remainder;
          done_d  = N_REQ'(1) << owner_q;
          state_d = S_RESP;
        end
      end
      S_ZERO: begin
        quo_d   = '1;
        rem_d   = div_dividend;
        dz_d    = 1'b1;
        done_d  = N_REQ'(1) << owner_q;
        state_d = S_RESP;
      end
      S_RESP: begin
        ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      zero_q       <= 1'b0;
      grant        <= '0;
      done         <= '0;
      div_start    <= 1'b0;
      div_zero     <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      zero_q       <= zero_d;
      grant        <= grant_d;
      done         <= done_d;
      div_start    <= start_d;
      div_zero     <= dz_d;
      quotient     <= quo_d;
      remainder    <= rem_d;
      div_dividend <= dd_d;
      div_divisor  <= dv_d;
    end
  end

endmodule
